// File: rtl/ahb_slave_mem_ws.sv
// AHB-Lite slave memory with fixed wait states and same-word write-to-read forwarding.
// Define AHBSLV_ERR_RESP_EN to get two-cycle ERROR responses for out-of-range or HSIZE>2 accesses.
module ahb_slave_mem_ws #(
  parameter int          AWIDTH      = 10,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  input  logic              HSEL,
  input  logic              HWRITE,
  input  logic [AWIDTH-1:0] HADDR,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  input  logic              HREADYIN,
  output logic              HREADYOUT,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic              HMASTLOCK,
  input  logic [3:0]        HPROT,
  output logic              HRESP
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           wr_q, wr_d, err_q, err_d;
  logic [IW-1:0]  idx_q, idx_d, rd_idx;
  logic [1:0]     lo_q, lo_d;
  logic [2:0]     sz_q, sz_d;
  logic [31:0]    rdata_q, rd_word, wmask, wword;
  logic           rd_load, commit, accept, a_err;
  logic [31:0]    mem_q [DEPTH];
  logic [IW-1:0]  a_idx;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HMASTLOCK, HPROT, HTRANS[0], HADDR};

  assign a_idx  = HADDR[IW+1:2];
  // Only sample an address phase while this slave is itself ready.
  assign accept = HSEL & HREADYIN & HTRANS[1] &
                  (state_q == S_IDLE || state_q == S_LAST || state_q == S_ERR2);

`ifdef AHBSLV_ERR_RESP_EN
  logic a_oor;
  if (IW + 2 < AWIDTH) begin : g_oor
    assign a_oor = |HADDR[AWIDTH-1:IW+2];
  end else begin : g_no_oor
    assign a_oor = 1'b0;
  end
  assign a_err = a_oor | (HSIZE > 3'd2);
  assign HRESP = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
  assign a_err = 1'b0;
  assign HRESP = 1'b0;
`endif

  function automatic logic [31:0] lane_mask(input logic [1:0] lo, input logic [2:0] sz);
    logic [3:0] l;
    case (sz)
      3'd0:    l = 4'b0001 << lo;
      3'd1:    l = lo[1] ? 4'b1100 : 4'b0011;
      default: l = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{l[i]}};
  endfunction

  assign wmask  = lane_mask(lo_q, sz_q);
  assign wword  = (mem_q[idx_q] & ~wmask) | (HWDATA & wmask);
  assign commit = (state_q == S_LAST) && wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    sz_d    = sz_q;
    rd_load = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      S_IDLE, S_LAST, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          wr_d  = HWRITE;
          err_d = a_err;
          idx_d = a_idx;
          lo_d  = HADDR[1:0];
          sz_d  = HSIZE;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else if (a_err) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_LAST;
            rd_load = ~HWRITE;
            rd_idx  = a_idx;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = err_q ? S_ERR1 : S_LAST;
          rd_load = ~wr_q & ~err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // A read entering LAST on the edge that commits a write to the same word sees the merged word.
  assign rd_word = (commit && rd_idx == idx_q) ? wword : mem_q[rd_idx];

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      lo_q    <= '0;
      sz_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      sz_q    <= sz_d;
      if (rd_load) rdata_q <= rd_word;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VALUE;
    end else if (commit) begin
      mem_q[idx_q] <= wword;
    end
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
endmodule
